// File: rtl/fire_expand3_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fire_expand3_pkg
//  Purpose : Shared types and helpers for the fire4/fire5 expand-3x3
//            sequencing controller.
//            fx3_state_t : controller state encoding
//            fx3_layer_t : which layer currently owns the MAC array
//            mac_len()   : accumulate cycles per output pixel
//  Revision: 1.0  initial release
// ============================================================================
package fire_expand3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_WAIT_WB = 3'd2,
    ST_CLR     = 3'd3,
    ST_DONE    = 3'd4
  } fx3_state_t;

  typedef enum logic {
    L4 = 1'b0,
    L5 = 1'b1
  } fx3_layer_t;

  // One output pixel needs a full kernel window over every input channel.
  function automatic int mac_len(input int kernel_dim, input int chin);
    return kernel_dim * kernel_dim * chin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fire_expand3_win_ctr.sv
`default_nettype none
// ============================================================================
//  Module  : fire_expand3_win_ctr
//  Purpose : Window counters for the expand-3x3 engine: weight-ROM address
//            within the current pixel, and pixels completed in the layer.
//  Ports   : clk, rst        clock / async active-high reset
//            i_clr           clear both counters (layer boundary)
//            i_addr_en       advance rom address by one
//            i_addr_wrap     return rom address to 0 (takes priority)
//            i_pix_inc       one more pixel completed
//            o_rom_addr      current weight-ROM address
//            o_addr_last     rom address is the final MAC of the pixel
//            o_pix_cnt       pixels completed
//  Revision: 1.0  initial release
// ============================================================================
module fire_expand3_win_ctr #(
  parameter int MAC_LEN = 288,
  parameter int AW      = 9,
  parameter int PW      = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_addr_en,
  input  logic          i_addr_wrap,
  input  logic          i_pix_inc,
  output logic [AW-1:0] o_rom_addr,
  output logic          o_addr_last,
  output logic [PW-1:0] o_pix_cnt
);

  localparam logic [AW-1:0] c_ADDR_LAST = AW'(MAC_LEN - 1);

  logic [AW-1:0] r_rom_addr;
  logic [PW-1:0] r_pix_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_addr <= '0;
      r_pix_cnt  <= '0;
    end else if (i_clr) begin
      r_rom_addr <= '0;
      r_pix_cnt  <= '0;
    end else begin
      if (i_addr_wrap) begin
        r_rom_addr <= '0;
      end else if (i_addr_en) begin
        r_rom_addr <= r_rom_addr + 1'b1;
      end
      if (i_pix_inc) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
    end
  end

  assign o_rom_addr  = r_rom_addr;
  assign o_pix_cnt   = r_pix_cnt;
  assign o_addr_last = (r_rom_addr == c_ADDR_LAST);

endmodule
`default_nettype wire

// File: rtl/fire_expand3_sched.sv
`default_nettype none
// ============================================================================
//  Module  : fire_expand3_sched
//  Purpose : Sequencing controller for the shared 128-MAC fire4/fire5
//            expand-3x3 engine. Latches layer start requests, arbitrates the
//            MAC array (fire4 first, since fire5 consumes its output), walks
//            each output pixel through MAC_LEN accumulate cycles followed by a
//            one-cycle clear/sample, and holds the layer finish flag until the
//            output RAM acknowledges writeback.
//  Ports   : clk, rst                  clock / async active-high reset
//            fire4_start, fire5_start  one-cycle layer run requests
//            ifm_stall                 input pixel not available this cycle
//            wb_busy                   output RAM cannot take a sample
//            ram_feedback_4/_5         RAM has consumed that layer's results
//            fire4/5_expand_3_en       MAC accumulate enables
//            rom_addr                  weight-ROM address (same cycle as en)
//            mac_clr, ofm_sample       accumulator clear / output strobe
//            pix_cnt                   pixels completed in current layer
//            fire4/5_expand_3_finish   layer done, awaiting RAM feedback
//            busy                      controller not idle
//  Revision: 1.0  initial release
// ============================================================================
module fire_expand3_sched
  import fire_expand3_pkg::*;
#(
  parameter  int WOUT       = 32,
  parameter  int CHIN       = 32,
  parameter  int KERNEL_DIM = 3,
  localparam int MAC_LEN    = mac_len(KERNEL_DIM, CHIN),
  localparam int AW         = $clog2(MAC_LEN),
  localparam int PW         = $clog2(WOUT * WOUT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fire4_start,
  input  logic          fire5_start,
  input  logic          ifm_stall,
  input  logic          wb_busy,
  input  logic          ram_feedback_4,
  input  logic          ram_feedback_5,
  output logic          fire4_expand_3_en,
  output logic          fire5_expand_3_en,
  output logic [AW-1:0] rom_addr,
  output logic          mac_clr,
  output logic          ofm_sample,
  output logic [PW-1:0] pix_cnt,
  output logic          fire4_expand_3_finish,
  output logic          fire5_expand_3_finish,
  output logic          busy
);

  localparam logic [PW-1:0] c_PIX_TOTAL = PW'(WOUT * WOUT);

  fx3_state_t    r_state;
  fx3_layer_t    r_layer;
  logic          r_pend4;
  logic          r_pend5;

  logic          w_idle;
  logic          w_take4;
  logic          w_take5;
  logic          w_step;
  logic          w_addr_last;
  logic          w_fb_sel;
  logic          w_leave_done;
  logic [PW-1:0] w_pix_next;
  logic          w_last_pix;

  // --------------------------------------------------------------------------
  // Arbitration and transition conditions
  // --------------------------------------------------------------------------
  assign w_idle       = (r_state == ST_IDLE);
  assign w_take4      = w_idle & r_pend4;
  assign w_take5      = w_idle & ~r_pend4 & r_pend5;
  assign w_step       = (r_state == ST_RUN) & ~ifm_stall;
  assign w_fb_sel     = (r_layer == L4) ? ram_feedback_4 : ram_feedback_5;
  assign w_leave_done = (r_state == ST_DONE) & w_fb_sel;
  assign w_pix_next   = pix_cnt + 1'b1;
  assign w_last_pix   = (w_pix_next == c_PIX_TOTAL);

  // --------------------------------------------------------------------------
  // Controller FSM, layer select and sticky request bits
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_layer <= L4;
      r_pend4 <= 1'b0;
      r_pend5 <= 1'b0;
    end else begin
      // A new start wins over the clear of the same bit, so a request that
      // lands on the arbitration cycle still produces another run later.
      r_pend4 <= fire4_start | (r_pend4 & ~w_take4);
      r_pend5 <= fire5_start | (r_pend5 & ~w_take5);

      case (r_state)
        ST_IDLE: begin
          if (w_take4) begin
            r_layer <= L4;
            r_state <= ST_RUN;
          end else if (w_take5) begin
            r_layer <= L5;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_step && w_addr_last) begin
            r_state <= wb_busy ? ST_WAIT_WB : ST_CLR;
          end
        end
        ST_WAIT_WB: begin
          if (!wb_busy) begin
            r_state <= ST_CLR;
          end
        end
        ST_CLR: begin
          r_state <= w_last_pix ? ST_DONE : ST_RUN;
        end
        ST_DONE: begin
          if (w_fb_sel) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Address / pixel counters. Counters are cleared while idle and on the
  // DONE exit edge so pix_cnt already reads 0 on the first IDLE cycle.
  // --------------------------------------------------------------------------
  fire_expand3_win_ctr #(
    .MAC_LEN (MAC_LEN),
    .AW      (AW),
    .PW      (PW)
  ) u_win_ctr (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_idle | w_leave_done),
    .i_addr_en   (w_step),
    .i_addr_wrap (w_step & w_addr_last),
    .i_pix_inc   (r_state == ST_CLR),
    .o_rom_addr  (rom_addr),
    .o_addr_last (w_addr_last),
    .o_pix_cnt   (pix_cnt)
  );

  // --------------------------------------------------------------------------
  // Output decode of registered state/layer; enables also gate on the stall
  // so a stalled cycle never accumulates.
  // --------------------------------------------------------------------------
  assign fire4_expand_3_en     = w_step & (r_layer == L4);
  assign fire5_expand_3_en     = w_step & (r_layer == L5);
  assign mac_clr               = (r_state == ST_CLR);
  assign ofm_sample            = (r_state == ST_CLR);
  assign fire4_expand_3_finish = (r_state == ST_DONE) & (r_layer == L4);
  assign fire5_expand_3_finish = (r_state == ST_DONE) & (r_layer == L5);
  assign busy                  = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_fire_expand3_sched.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fire_expand3_sched
//  Purpose : Directed self-checking bench for fire_expand3_sched with
//            WOUT=2, CHIN=1 (MAC_LEN=9, 4 pixels per layer).
//  Revision: 1.0  initial release
// ============================================================================
module tb_fire_expand3_sched;

  localparam int MACL = 9;
  localparam int NPIX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       fire4_start, fire5_start, ifm_stall, wb_busy;
  logic       ram_feedback_4, ram_feedback_5;
  logic       fire4_expand_3_en, fire5_expand_3_en;
  logic [3:0] rom_addr;
  logic       mac_clr, ofm_sample;
  logic [2:0] pix_cnt;
  logic       fire4_expand_3_finish, fire5_expand_3_finish, busy;

  int n_vec  = 0;
  int n_miss = 0;
  int n_clr  = 0;

  always #5 clk = ~clk;

  fire_expand3_sched #(
    .WOUT       (2),
    .CHIN       (1),
    .KERNEL_DIM (3)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .fire4_start           (fire4_start),
    .fire5_start           (fire5_start),
    .ifm_stall             (ifm_stall),
    .wb_busy               (wb_busy),
    .ram_feedback_4        (ram_feedback_4),
    .ram_feedback_5        (ram_feedback_5),
    .fire4_expand_3_en     (fire4_expand_3_en),
    .fire5_expand_3_en     (fire5_expand_3_en),
    .rom_addr              (rom_addr),
    .mac_clr               (mac_clr),
    .ofm_sample            (ofm_sample),
    .pix_cnt               (pix_cnt),
    .fire4_expand_3_finish (fire4_expand_3_finish),
    .fire5_expand_3_finish (fire5_expand_3_finish),
    .busy                  (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f4, input logic f5, input logic st,
                       input logic wb, input logic fb4, input logic fb5);
    fire4_start    = f4;
    fire5_start    = f5;
    ifm_stall      = st;
    wb_busy        = wb;
    ram_feedback_4 = fb4;
    ram_feedback_5 = fb5;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic e4, input logic e5,
                            input int rom, input logic clr, input int pix,
                            input logic fn4, input logic fn5, input logic bz);
    if (mac_clr === 1'b1) n_clr++;
    check({tag, ".en4"},  32'(fire4_expand_3_en),     32'(e4));
    check({tag, ".en5"},  32'(fire5_expand_3_en),     32'(e5));
    check({tag, ".rom"},  32'(rom_addr),              32'(rom));
    check({tag, ".clr"},  32'(mac_clr),               32'(clr));
    check({tag, ".smp"},  32'(ofm_sample),            32'(clr));
    check({tag, ".pix"},  32'(pix_cnt),               32'(pix));
    check({tag, ".fin4"}, 32'(fire4_expand_3_finish), 32'(fn4));
    check({tag, ".fin5"}, 32'(fire5_expand_3_finish), 32'(fn5));
    check({tag, ".busy"}, 32'(busy),                  32'(bz));
  endtask

  task automatic idle_cycle(input string tag);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(tag, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Start pulse cycle plus the latch cycle; both are still IDLE.
  task automatic start_seq(input logic f4, input logic f5);
    tick();
    drive(f4, f5, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("start", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle_cycle("latch");
  endtask

  // One pixel: MAC_LEN enabled cycles (plus optional stall and writeback
  // wait), then the clear/sample cycle. s4_at pulses fire4_start mid-run.
  task automatic run_pixel(input logic is5, input int p, input int stall_at,
                           input int stall_len, input int wb_len, input int s4_at);
    logic e4, e5;
    e4 = ~is5;
    e5 = is5;
    for (int k = 0; k < MACL; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          tick();
          drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
          expect_out("stall", 1'b0, 1'b0, k, 1'b0, p, 1'b0, 1'b0, 1'b1);
        end
      end
      tick();
      drive(k == s4_at, 1'b0, 1'b0, (k == MACL-1) && (wb_len > 0), 1'b0, 1'b0);
      expect_out("run", e4, e5, k, 1'b0, p, 1'b0, 1'b0, 1'b1);
    end
    for (int w = 1; w <= wb_len; w++) begin
      tick();
      drive(1'b0, 1'b0, 1'b1, w < wb_len, 1'b0, 1'b0);
      expect_out("wait_wb", 1'b0, 1'b0, 0, 1'b0, p, 1'b0, 1'b0, 1'b1);
    end
    tick();
    drive(1'b0, 1'b0, wb_len > 0, 1'b0, 1'b0, 1'b0);
    expect_out("clr", 1'b0, 1'b0, 0, 1'b1, p, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic done_cycle(input logic is5, input logic fb4, input logic fb5);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, fb4, fb5);
    expect_out("done", 1'b0, 1'b0, 0, 1'b0, NPIX, ~is5, is5, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fire4_start = 1'b0; fire5_start = 1'b0; ifm_stall = 1'b0; wb_busy = 1'b0;
    ram_feedback_4 = 1'b0; ram_feedback_5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Single fire4 run; wrong feedback held off, then real feedback.
    start_seq(1'b1, 1'b0);
    n_clr = 0;
    for (int p = 0; p < NPIX; p++) run_pixel(1'b0, p, -1, 0, 0, -1);
    done_cycle(1'b0, 1'b0, 1'b0);
    done_cycle(1'b0, 1'b0, 1'b0);
    done_cycle(1'b0, 1'b0, 1'b1);
    done_cycle(1'b0, 1'b0, 1'b0);
    done_cycle(1'b0, 1'b1, 1'b0);
    check("clr_count_a", 32'(n_clr), 32'(NPIX));
    idle_cycle("after_a");

    // Simultaneous starts: fire4 first, feedback on the DONE entry cycle.
    start_seq(1'b1, 1'b1);
    for (int p = 0; p < NPIX; p++) run_pixel(1'b0, p, -1, 0, 0, -1);
    done_cycle(1'b0, 1'b1, 1'b0);
    idle_cycle("gap_4to5");
    for (int p = 0; p < NPIX; p++) run_pixel(1'b1, p, -1, 0, 0, -1);
    done_cycle(1'b1, 1'b1, 1'b0);
    done_cycle(1'b1, 1'b0, 1'b1);
    idle_cycle("after_b");

    // Stall, writeback backpressure and a re-issued fire4_start.
    start_seq(1'b1, 1'b0);
    n_clr = 0;
    run_pixel(1'b0, 0, 4, 3, 0, -1);
    run_pixel(1'b0, 1, -1, 0, 5, -1);
    run_pixel(1'b0, 2, -1, 0, 0, 2);
    run_pixel(1'b0, 3, -1, 0, 0, -1);
    done_cycle(1'b0, 1'b1, 1'b0);
    check("clr_count_c", 32'(n_clr), 32'(NPIX));
    idle_cycle("rerun_gap");
    for (int p = 0; p < NPIX; p++) run_pixel(1'b0, p, -1, 0, 0, -1);
    done_cycle(1'b0, 1'b1, 1'b0);
    idle_cycle("after_c");

    // Reset mid-layer with a fire4 request pending.
    start_seq(1'b0, 1'b1);
    run_pixel(1'b1, 0, -1, 0, 0, -1);
    run_pixel(1'b1, 1, -1, 0, 0, 3);
    for (int k = 0; k <= 5; k++) begin
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("pre_rst", 1'b0, 1'b1, k, 1'b0, 2, 1'b0, 1'b0, 1'b1);
    end
    rst = 1'b1;
    #1;
    expect_out("rst_async", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("rst_hold", 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle_cycle("post_rst0");
    idle_cycle("post_rst1");
    idle_cycle("post_rst2");
    start_seq(1'b0, 1'b1);
    for (int p = 0; p < NPIX; p++) run_pixel(1'b1, p, -1, 0, 0, -1);
    done_cycle(1'b1, 1'b0, 1'b1);
    idle_cycle("after_d");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
